alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU (AND/OR/ADD/SUB/SLT, 4-bit control code) between two requesters, e.g. an execute stage and a branch-compare unit.
- Arbitrates with round-robin or fixed priority and latches the winning operands.
- Computes in a dedicated cycle and returns a registered result tagged with the requester id over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand and result width in bits.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0's operation is accepted this cycle.
- req0_ctl  input  4  requester 0 ALU control code.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  id of the requester that owns the result.
- rsp_data  output  WIDTH  ALU result.
- rsp_zero  output  1  high when rsp_data == 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, busy=0, RR pointer=0, latched operands=0. req*_ready are combinational and therefore 0.
- Reset mid-operation: the in-flight operation is dropped silently; no response is issued.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester and assert reqN_ready combinationally for that requester only, in the same cycle.
  - Latch its ctl, a, b and id; next state EXEC.
  - No valid requests: stay in IDLE.
- Grant rule when both requesters are valid:
  - FIXED_PRIO=0: grant the requester named by the RR pointer.
  - FIXED_PRIO=1: grant requester 0.
  - Only one valid: grant it regardless of the pointer.
- EXEC:
  - Compute the result from the latched operands and register rsp_data, rsp_zero and rsp_id.
  - Set rsp_valid=1; next state RESP.
- Opcodes:
  - 0000: A & B.
  - 0001: A | B.
  - 0010: A + B, modulo 2^WIDTH, carry discarded.
  - 0110: A - B, modulo 2^WIDTH.
  - 0111: unsigned A < B gives 1, else 0.
  - Any other code gives 0, so rsp_zero=1.
- RESP:
  - Hold rsp_valid, rsp_data, rsp_zero and rsp_id stable until rsp_ready=1.
  - On the rsp_ready handshake cycle, clear rsp_valid, set RR pointer = ~granted id, go to IDLE.
  - rsp_ready while not in RESP is ignored.
- Timing and throughput:
  - Latency: accept at cycle N gives rsp_valid at cycle N+2.
  - Maximum throughput is one operation per 3 cycles.
  - No new grant is made until the response handshake completes; only one operation is in flight.
- Requester-side rules:
  - A requester must hold valid and operands stable until it sees ready.
  - The non-granted requester sees ready=0 and keeps waiting.
- The RR pointer updates only on a response handshake, never on a grant.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_ILLEGAL_OP_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0), registered in EXEC alongside rsp_data.
  - rsp_err=1 when the latched ctl is not one of 0000/0001/0010/0110/0111.
  - rsp_err is held through RESP and cleared on the handshake.
  - rsp_data/rsp_zero still behave as for an unknown code (0 and 1).
- Undefined: no rsp_err port; unknown codes silently give 0 with rsp_zero=1.

Test Plan:
- Single request: req0 ctl=0010, A=5, B=7 -> req0_ready in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
- Round-robin, FIXED_PRIO=0, after reset: both valid (req0 SUB 9-9, req1 SLT 3<4).
  - First grant goes to req0; response rsp_data=0, rsp_zero=1.
  - Next grant goes to req1; response rsp_data=1, rsp_id=1.
  - With both held valid afterwards, grants alternate 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid/data/id stable throughout, both req*_ready=0, busy=1. Release gives one handshake, then IDLE.
- Wrap and logic: ADD FFFFFFFF+1 -> 0, zero=1. SUB 0-1 -> FFFFFFFF. AND F0F0F0F0&0FF00FF0 -> 00F000F0. OR -> FFF0FFF0.
- Reset in EXEC: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release, no stale rsp_valid, and the pointer favours req0.
- Illegal opcode, with and without the macro: ctl=1111 -> rsp_data=0, rsp_zero=1; with the macro defined, additionally rsp_err=1 during RESP.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU (AND/OR/ADD/SUB/SLT) with a registered, id-tagged valid/ready response.
// Optional rsp_err output for unknown opcodes when ALU_SHARE_ARBITER_ILLEGAL_OP_EN is defined.
module alu_share_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
    output logic             rsp_err,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       ctl_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             ptr_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q;
    logic             busy_q;
    logic             rsp_err_q;

    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;

    // Grant is combinational in IDLE; forced low while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (req0_valid && req1_valid) begin
                if (FIXED_PRIO || !ptr_q) gnt0 = 1'b1;
                else                      gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (ctl_q)
            4'b0000: alu_res = a_q & b_q;
            4'b0001: alu_res = a_q | b_q;
            4'b0010: alu_res = a_q + b_q;
            4'b0110: alu_res = a_q - b_q;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctl_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        ctl_q   <= gnt1 ? req1_ctl : req0_ctl;
                        a_q     <= gnt1 ? req1_a   : req0_a;
                        b_q     <= gnt1 ? req1_b   : req0_b;
                        id_q    <= gnt1;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_res;
                    rsp_zero_q  <= (alu_res == '0);
                    rsp_id_q    <= id_q;
                    rsp_err_q   <= alu_illegal;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Pointer moves only on the response handshake, away from the owner just served.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        ptr_q       <= ~id_q;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = busy_q;
`ifdef ALU_SHARE_ARBITER_ILLEGAL_OP_EN
    assign rsp_err   = rsp_err_q;
`else
    logic unused_err;
    assign unused_err = rsp_err_q;
`endif

endmodule
